// File: rtl/aes_pack.sv
// -----------------------------------------------------------------------------
// aes_pack
// Shared constants and types for the AES word generator controller.
//   - Avalon-MM address/data widths and the peripheral base address
//   - Register offsets and absolute register addresses
//   - CTRL_STATUS bit indices
//   - Controller FSM state encoding
//   - Saturating increment helper used by the word counters
// -----------------------------------------------------------------------------
package aes_pack;

    // Bus and counter widths
    localparam int ADDRESS_SIZE      = 32;
    localparam int REG_SIZE          = 32;
    localparam int WORD_COUNTER_SIZE = 8;

    // Base address of the register map
    localparam logic [ADDRESS_SIZE-1:0] PERIPHERAL_ADDR = 32'h0000_1000;

    // Register offsets from PERIPHERAL_ADDR
    localparam logic [ADDRESS_SIZE-1:0] MSG_WORD_CNT     = 32'h0000_0000;
    localparam logic [ADDRESS_SIZE-1:0] ADDER_WORD_CNT   = 32'h0000_0004;
    localparam logic [ADDRESS_SIZE-1:0] REMOVER_WORD_CNT = 32'h0000_0008;
    localparam logic [ADDRESS_SIZE-1:0] CTRL_STATUS      = 32'h0000_000C;

    // Absolute register addresses; a hit requires an exact match
    localparam logic [ADDRESS_SIZE-1:0] ADDR_MSG_WORD_CNT     = PERIPHERAL_ADDR + MSG_WORD_CNT;
    localparam logic [ADDRESS_SIZE-1:0] ADDR_ADDER_WORD_CNT   = PERIPHERAL_ADDR + ADDER_WORD_CNT;
    localparam logic [ADDRESS_SIZE-1:0] ADDR_REMOVER_WORD_CNT = PERIPHERAL_ADDR + REMOVER_WORD_CNT;
    localparam logic [ADDRESS_SIZE-1:0] ADDR_CTRL_STATUS      = PERIPHERAL_ADDR + CTRL_STATUS;

    // CTRL_STATUS bit indices
    localparam int STATUS_BUSY_BIT    = 0;
    localparam int STATUS_DONE_BIT    = 1;
    localparam int STATUS_OVERRUN_BIT = 2;

    // Controller FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    localparam logic [WORD_COUNTER_SIZE-1:0] CNT_ONE = 1;
    localparam logic [WORD_COUNTER_SIZE-1:0] CNT_MAX = '1;

    // Increment that sticks at the all-ones value instead of wrapping
    function automatic logic [WORD_COUNTER_SIZE-1:0] sat_inc(
        input logic [WORD_COUNTER_SIZE-1:0] v
    );
        if (v == CNT_MAX) begin
            return v;
        end
        return v + CNT_ONE;
    endfunction

endpackage

// File: rtl/aes_word_counter.sv
// -----------------------------------------------------------------------------
// aes_word_counter
// Saturating word counter with synchronous clear and increment.
// Clear has priority over increment. The count sticks at its maximum value.
//
// Ports
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset
//   clr_i    in   clear count to zero
//   inc_i    in   increment count by one (saturating)
//   count_o  out  current count
// -----------------------------------------------------------------------------
module aes_word_counter
    import aes_pack::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr_i,
    input  logic                         inc_i,
    output logic [WORD_COUNTER_SIZE-1:0] count_o
);

    logic [WORD_COUNTER_SIZE-1:0] count_q;
    logic [WORD_COUNTER_SIZE-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = sat_inc(count_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/aes_word_gen_ctrl.sv
// -----------------------------------------------------------------------------
// aes_word_gen_ctrl
// Avalon-MM slave controller for the AES word generator. Software writes a
// nonzero message word count to MSG_WORD_CNT, which launches a generator run.
// The block counts words leaving the adder and remover stages, flags
// completion when the remover count reaches the programmed count, and
// exposes all counters and status for readback.
//
// Optional feature macro: AES_WORD_CTRL_IRQ_EN
//   defined   -> adds output irq (registered done bit); any write to
//                CTRL_STATUS clears done
//   undefined -> no irq port; writes to CTRL_STATUS are dropped
//
// Ports
//   clk                in   clock, rising edge
//   rst                in   synchronous active-high reset
//   avs_address        in   byte address
//   avs_read           in   read request
//   avs_write          in   write request
//   avs_writedata      in   write data
//   avs_readdata       out  read data, valid with avs_readdatavalid
//   avs_readdatavalid  out  read response strobe, one cycle after avs_read
//   gen_start          out  one-cycle start pulse to the word generator
//   gen_word_cnt       out  programmed message word count
//   adder_word         in   one-cycle strobe per word out of the adder
//   remover_word       in   one-cycle strobe per word out of the remover
//   busy               out  run in progress
//   dbg_state          out  current FSM state (state_t encoding)
//   irq                out  done interrupt (only with AES_WORD_CTRL_IRQ_EN)
//
// Bus handshake: there is no waitrequest. Every avs_read is answered exactly
// one cycle later with avs_readdatavalid=1; every avs_write is accepted in
// the cycle it is presented. A read and write in the same cycle are both
// accepted, and the read returns the value held before the write.
// -----------------------------------------------------------------------------
module aes_word_gen_ctrl
    import aes_pack::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ADDRESS_SIZE-1:0]      avs_address,
    input  logic                         avs_read,
    input  logic                         avs_write,
    input  logic [REG_SIZE-1:0]          avs_writedata,
    output logic [REG_SIZE-1:0]          avs_readdata,
    output logic                         avs_readdatavalid,
    output logic                         gen_start,
    output logic [WORD_COUNTER_SIZE-1:0] gen_word_cnt,
    input  logic                         adder_word,
    input  logic                         remover_word,
    output logic                         busy,
    output logic [1:0]                   dbg_state
`ifdef AES_WORD_CTRL_IRQ_EN
    ,
    output logic                         irq
`endif
);

    // ------------------------------------------------------------------
    // Register state
    // ------------------------------------------------------------------
    state_t                       state_q;
    logic [WORD_COUNTER_SIZE-1:0] msg_cnt_q;
    logic                         gen_start_q;
    logic                         busy_q;
    logic                         done_q;
    logic                         overrun_q;
    logic [REG_SIZE-1:0]          readdata_q;
    logic                         readvalid_q;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic wr_msg;
    logic start_wr;
    logic [WORD_COUNTER_SIZE-1:0] wr_cnt;

    assign wr_msg = avs_write && (avs_address == ADDR_MSG_WORD_CNT);
    assign wr_cnt = avs_writedata[WORD_COUNTER_SIZE-1:0];

    // Only a nonzero count written while idle launches a run
    assign start_wr = (state_q == ST_IDLE) && wr_msg && (wr_cnt != '0);

    // Upper write-data bits are never stored
    logic unused_wdata;
    assign unused_wdata = ^avs_writedata[REG_SIZE-1:WORD_COUNTER_SIZE];

`ifdef AES_WORD_CTRL_IRQ_EN
    logic wr_ctrl;
    assign wr_ctrl = avs_write && (avs_address == ADDR_CTRL_STATUS);
`endif

    // ------------------------------------------------------------------
    // Word counters: strobes count only during RUN; a launching write
    // clears both.
    // ------------------------------------------------------------------
    logic                         adder_inc;
    logic                         rem_inc;
    logic [WORD_COUNTER_SIZE-1:0] adder_cnt;
    logic [WORD_COUNTER_SIZE-1:0] rem_cnt;
    logic [WORD_COUNTER_SIZE-1:0] rem_cnt_d;

    assign adder_inc = (state_q == ST_RUN) && adder_word;
    assign rem_inc   = (state_q == ST_RUN) && remover_word;
    assign rem_cnt_d = sat_inc(rem_cnt);

    aes_word_counter u_adder_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (start_wr),
        .inc_i   (adder_inc),
        .count_o (adder_cnt)
    );

    aes_word_counter u_remover_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (start_wr),
        .inc_i   (rem_inc),
        .count_o (rem_cnt)
    );

    // The run finishes on the strobe that brings the remover count up to
    // the programmed value, so done/busy update together with the counter.
    logic run_done;
    assign run_done = rem_inc && (rem_cnt_d == msg_cnt_q);

    // ------------------------------------------------------------------
    // Controller FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            msg_cnt_q   <= '0;
            gen_start_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            gen_start_q <= 1'b0;

            // Remover activity outside a run is flagged; a launching write
            // below overrides this and clears it.
            if ((state_q != ST_RUN) && remover_word) begin
                overrun_q <= 1'b1;
            end

`ifdef AES_WORD_CTRL_IRQ_EN
            if (wr_ctrl) begin
                done_q <= 1'b0;
            end
`endif

            case (state_q)
                ST_IDLE: begin
                    if (wr_msg) begin
                        msg_cnt_q <= wr_cnt;
                    end
                    if (start_wr) begin
                        done_q      <= 1'b0;
                        overrun_q   <= 1'b0;
                        gen_start_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= ST_START;
                    end
                end
                ST_START: begin
                    state_q <= ST_RUN;
                end
                ST_RUN: begin
                    if (run_done) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read path: fixed one-cycle latency, unmapped addresses return 0.
    // Sampling happens before this edge's writes land, so a concurrent
    // write is not reflected in the returned data.
    // ------------------------------------------------------------------
    logic [REG_SIZE-1:0] rdata_d;

    always_comb begin
        rdata_d = '0;
        case (avs_address)
            ADDR_MSG_WORD_CNT:     rdata_d[WORD_COUNTER_SIZE-1:0] = msg_cnt_q;
            ADDR_ADDER_WORD_CNT:   rdata_d[WORD_COUNTER_SIZE-1:0] = adder_cnt;
            ADDR_REMOVER_WORD_CNT: rdata_d[WORD_COUNTER_SIZE-1:0] = rem_cnt;
            ADDR_CTRL_STATUS: begin
                rdata_d[STATUS_BUSY_BIT]    = busy_q;
                rdata_d[STATUS_DONE_BIT]    = done_q;
                rdata_d[STATUS_OVERRUN_BIT] = overrun_q;
            end
            default: rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            readdata_q  <= '0;
            readvalid_q <= 1'b0;
        end else begin
            readvalid_q <= avs_read;
            readdata_q  <= avs_read ? rdata_d : '0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign avs_readdata      = readdata_q;
    assign avs_readdatavalid = readvalid_q;
    assign gen_start         = gen_start_q;
    assign gen_word_cnt      = msg_cnt_q;
    assign busy              = busy_q;
    assign dbg_state         = state_q;

`ifdef AES_WORD_CTRL_IRQ_EN
    assign irq = done_q;
`endif

endmodule

// File: doc/aes_word_gen_ctrl.md
# aes_word_gen_ctrl

Avalon-MM slave controller that configures and sequences the AES word generator. Software programs a message word count at the peripheral register map, which starts a generator run. The block counts words leaving the adder and remover stages, signals completion, and exposes all counts and status for readback. It sits between the system Avalon-MM interconnect and the word generator datapath.

## Interface
- PERIPHERAL_ADDR, 'h1000, base address of the register map (package constant)
- WORD_COUNTER_SIZE, 8, width of message count and word counters (package constant)
- ADDRESS_SIZE / REG_SIZE, 32 / 32, Avalon address and data widths (package constants)
- clk  in  1  single clock; all logic is on the rising edge
- rst  in  1  synchronous, active-high reset
- avs_address  in  ADDRESS_SIZE  byte address
- avs_read  in  1  read request
- avs_write  in  1  write request
- avs_writedata  in  REG_SIZE  write data
- avs_readdata  out  REG_SIZE  read data, valid with avs_readdatavalid
- avs_readdatavalid  out  1  read response strobe
- gen_start  out  1  one-cycle start pulse to the word generator
- gen_word_cnt  out  WORD_COUNTER_SIZE  programmed message word count, held stable
- adder_word  in  1  one-cycle strobe per word out of the adder
- remover_word  in  1  one-cycle strobe per word out of the remover
- busy  out  1  run in progress

## Operation
- Register map, offsets from PERIPHERAL_ADDR: MSG_WORD_CNT 'h0 (RW), ADDER_WORD_CNT 'h4 (RO), REMOVER_WORD_CNT 'h8 (RO), CTRL_STATUS 'hC (RO).
- A hit requires avs_address == PERIPHERAL_ADDR + offset exactly. Any other address is unmapped.
- Unmapped reads return 0 and still produce avs_readdatavalid. Unmapped writes are dropped.
- CTRL_STATUS bits:
  - bit0 busy
  - bit1 done: sticky, cleared on start
  - bit2 overrun: a remover strobe arrived while not in RUN; cleared on start
- Upper bits of CTRL_STATUS read 0.
- Writes to MSG_WORD_CNT use writedata[7:0] and ignore the upper bits. Reads zero-extend.
- Writes to read-only registers are dropped.
- FSM states are IDLE, START and RUN.
- IDLE:
  - A write of a nonzero value to MSG_WORD_CNT loads the value.
  - The same write clears both word counters, done and overrun, then moves to START.
  - A write of 0 loads the value but does not start a run.
- START:
  - gen_start=1 for exactly this cycle, then move to RUN.
- RUN:
  - Each adder_word or remover_word strobe increments its counter. The counters saturate at 255.
  - When the remover counter reaches MSG_WORD_CNT, set done and return to IDLE.
- Writes to MSG_WORD_CNT during START or RUN are dropped, and the register is unchanged.
- Strobes while in IDLE or START are not counted. A remover strobe in those states sets overrun.
- Simultaneous adder and remover strobes are both counted in the same cycle.
- Simultaneous read and write: the write takes effect, and the read returns the pre-write value.

## Timing
- Reset values:
  - avs_readdata=0, avs_readdatavalid=0, gen_start=0, gen_word_cnt=0, busy=0.
  - All counters and status bits 0; FSM in IDLE.
- Read latency is fixed at 1 cycle: avs_readdatavalid is asserted the cycle after avs_read. There is no waitrequest, and back-to-back reads are supported.
- A start write in cycle N gives gen_start=1 in cycle N+1. busy=1 from N+1 until the run ends.
- gen_word_cnt updates in N+1 and is held until the next accepted write.
- The final remover strobe in cycle M gives: counter updated, done=1 and busy=0 in M+1.
- A counter change becomes visible to a read issued the cycle after the strobe.
- rst asserted mid-run returns every signal to its reset value on the next edge, with no gen_start.

## Configuration
- AES_WORD_CTRL_IRQ_EN:
  - Defined: adds an output port irq (1 bit), which is the registered done bit. A write of any value to CTRL_STATUS clears done and deasserts irq in the next cycle.
  - Undefined: the irq port does not exist, and writes to CTRL_STATUS are dropped.

## Structure
- Add CTRL_STATUS = 'hC and the status bit indices to aes_pack, alongside the existing address constants.
- Add the FSM state enum to aes_pack.
- One sub-module, aes_word_counter: an 8-bit saturating counter with clear and increment. It is instantiated twice, once for the adder and once for the remover.

## Test plan
- Reset, then read 'h100C -> readdata 0 one cycle later.
- Write 'h1000=3, then 3 remover strobes -> gen_start pulse in the cycle after the write. 'h1008 reads 3 and 'h100C reads 'h1 → 'h2 after the third strobe.
- During RUN, write 'h1000=9 -> ignored: 'h1000 still reads 3 and no second gen_start.
- Adder and remover strobes in the same cycle 300 times with MSG_WORD_CNT=255 -> counters saturate at 255 and done sets.
- Read 'h2000 and write 'h1004=5 -> read returns 0 with readdatavalid. 'h1004 is unchanged.
- rst asserted mid-run -> busy=0, all counters 0, and the next start runs normally. With AES_WORD_CTRL_IRQ_EN defined, irq rises with done and clears on a write to 'h100C.
